sf_rd_stream_adapter: RTL

- Sits directly downstream of the synchronous 8-bit FIFO.
- Pops words from the FIFO using its r_en / empty / data_out handshake, where data_out is registered and valid one cycle after r_en.
- Re-presents the words on a valid/ready stream for the next stage.
- Holds a 2-entry output buffer, so it can read at full rate (one word per cycle) with no loss and no duplication while downstream stalls.

---
 rtl/sf_rd_stream_adapter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sf_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// sf_rd_stream_adapter
//
// Pops words out of a synchronous FIFO and re-presents them on a valid/ready
// stream. The FIFO's data_out is registered, so a word arrives one cycle after
// its r_en. A 2-entry buffer absorbs that latency. Reads can then run at one
// word per cycle while downstream applies backpressure, with no word lost and
// none repeated.
//
// Ports
//   clk            single clock, all logic on posedge
//   rst            synchronous reset, active high; overrides every other input
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en      FIFO read enable (combinational)
//   flush          synchronous discard of buffered and in-flight words
//   m_valid        stream word available (register-derived)
//   m_ready        downstream accepts the word
//   m_data         stream word (register-derived)
//
// Optional feature, macro SF_RD_STATS_EN:
//   xfer_cnt[15:0]   counts accepted words (m_valid & m_ready)
//   stall_cnt[15:0]  counts cycles with m_valid & !m_ready
//   Both counters wrap, clear on rst and ignore flush. When the macro is left
//   undefined, neither these ports nor the counters exist.
// -----------------------------------------------------------------------------
module sf_rd_stream_adapter #(
   parameter int DATA_W    = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data_out,
   output logic              fifo_r_en,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data
`ifdef SF_RD_STATS_EN
   ,
   output logic [15:0]       xfer_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   // The pointer and count arithmetic below relies on exactly two entries.
   generate
      if (BUF_DEPTH != 2) begin : g_bad_depth
         $error("sf_rd_stream_adapter: BUF_DEPTH must be 2");
      end
   endgenerate

   logic [1:0]                       cnt;       // buffered words, 0..2
   logic                             inflight;  // a read was issued last cycle
   logic                             wr_ptr;
   logic                             rd_ptr;
   logic [BUF_DEPTH-1:0][DATA_W-1:0] buf_q;

   logic       pop;
   logic [2:0] occ_next;  // words held next cycle if no new read is issued

   assign pop      = m_valid & m_ready;
   // cnt + inflight >= pop always holds, because pop needs cnt != 0.
   assign occ_next = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

   // Only a read that is sure to find a free slot when its data lands may be
   // issued. That makes overflow impossible. This is the only path from
   // m_ready to fifo_r_en.
   assign fifo_r_en = !fifo_empty && !flush && !rst && (occ_next < 3'd2);

   assign m_valid = (cnt != 2'd0);
   assign m_data  = buf_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 2'd0;
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         buf_q    <= '0;
      end else if (flush) begin
         // A word in flight from last cycle's read is dropped. Its data is
         // never captured.
         cnt      <= 2'd0;
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         inflight <= fifo_r_en;
         if (inflight) begin
            buf_q[wr_ptr] <= fifo_data_out;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         // A capture and a pop in the same cycle leave cnt unchanged.
         cnt <= occ_next[1:0];
      end
   end

`ifdef SF_RD_STATS_EN
   // The counters run on the stream handshake only, so flush does not touch
   // them.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt  <= 16'd0;
         stall_cnt <= 16'd0;
      end else begin
         if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
         end
         if (m_valid && !m_ready) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
